vc_credit_sender: RTL and testbench

- Producer-side end of a credit-based link that feeds a remote vc-style queue across a long or registered channel.
- Accepts messages on a val/rdy enqueue interface and forwards them as a registered, non-stallable send stream, with no ready signal on the send side.
- Tracks free remote queue entries with a credit counter. The remote side returns one credit per dequeued message.
- Guarantees that the remote queue never overflows, so the channel needs no backpressure wire.

---
 rtl/vc_credit_sender.sv | 89 ++++++++
 tb/tb_vc_credit_sender.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vc_credit_sender.sv
// vc_credit_sender: producer-side end of a credit-based link.
// Messages taken on the enq val/rdy port are forwarded one cycle later on a
// registered, non-stallable send stream. A credit counter tracks free entries
// in the remote queue. Each accepted message consumes one credit, and each
// credit_ret pulse gives one back. Because of this the remote queue can never
// overflow and the link needs no backpressure wire.
//
// Handshake: enq_msg is accepted on a rising edge where enq_val && enq_rdy.
// enq_rdy depends only on registered state (credits != 0), so the producer may
// compute enq_val from enq_rdy without forming a combinational loop. The send
// side has no ready: when send_val is 1, the receiver must capture send_msg in
// that cycle.
module vc_credit_sender #(
    parameter int p_msg_nbits   = 32,
    parameter int p_num_credits = 2,
    localparam int c_cnt_nbits  = $clog2(p_num_credits + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val,
    output logic                   enq_rdy,
    input  logic [p_msg_nbits-1:0] enq_msg,
    output logic                   send_val,
    output logic [p_msg_nbits-1:0] send_msg,
    input  logic                   credit_ret,
    output logic [c_cnt_nbits-1:0] credits,
    output logic                   credit_err
);

    localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_num_credits);
    localparam logic [c_cnt_nbits-1:0] c_one = c_cnt_nbits'(1);

    logic [c_cnt_nbits-1:0] credits_q, credits_d;
    logic                   send_val_q, send_val_d;
    logic [p_msg_nbits-1:0] send_msg_q, send_msg_d;
    logic                   credit_err_q, credit_err_d;
    logic                   do_enq;
    logic                   overflow;

    // Ready comes only from the registered count. A credit returned in a
    // zero-credit cycle therefore takes effect in the next cycle.
    always_comb begin
        enq_rdy  = (credits_q != '0);
        do_enq   = enq_val && enq_rdy;
        overflow = credit_ret && !do_enq && (credits_q == c_max);
    end

    // Next-state logic for the credit counter, send register and error flag.
    always_comb begin
        credits_d    = credits_q;
        send_val_d   = do_enq;
        send_msg_d   = send_msg_q;
        credit_err_d = credit_err_q | overflow;
        if (do_enq) begin
            send_msg_d = enq_msg;
        end
        if (do_enq && !credit_ret) begin
            // Cannot underflow: do_enq already implies credits_q != 0.
            credits_d = credits_q - c_one;
        end else if (!do_enq && credit_ret && (credits_q != c_max)) begin
            // Saturate at the remote queue depth. The excess return is flagged instead.
            credits_d = credits_q + c_one;
        end
    end

    // State registers. Reset clears in-flight sends and restores every credit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits_q    <= c_max;
            send_val_q   <= 1'b0;
            send_msg_q   <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            send_val_q   <= send_val_d;
            send_msg_q   <= send_msg_d;
            credit_err_q <= credit_err_d;
        end
    end

    // Drive the outputs straight from the registers.
    always_comb begin
        credits    = credits_q;
        send_val   = send_val_q;
        send_msg   = send_msg_q;
        credit_err = credit_err_q;
    end

endmodule

// File: tb/tb_vc_credit_sender.sv
// Testbench for vc_credit_sender with p_msg_nbits=8 and p_num_credits=2.
// The test has three phases: a table of directed vectors, a hand-written
// asynchronous reset in the middle of traffic, and random traffic checked
// against a small credit model. Accepted messages are pushed to exp_q and
// popped when send_val appears.
module tb_vc_credit_sender;

    localparam int W  = 8;
    localparam int NC = 2;
    localparam int CW = $clog2(NC + 1);

    logic          clk;
    logic          reset;
    logic          enq_val;
    logic          enq_rdy;
    logic [W-1:0]  enq_msg;
    logic          send_val;
    logic [W-1:0]  send_msg;
    logic          credit_ret;
    logic [CW-1:0] credits;
    logic          credit_err;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    vc_credit_sender #(.p_msg_nbits(W), .p_num_credits(NC)) dut (
        .clk        (clk),
        .reset      (reset),
        .enq_val    (enq_val),
        .enq_rdy    (enq_rdy),
        .enq_msg    (enq_msg),
        .send_val   (send_val),
        .send_msg   (send_msg),
        .credit_ret (credit_ret),
        .credits    (credits),
        .credit_err (credit_err)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ev;
        logic [W-1:0]  msg;
        logic          cr;
        logic          exp_rdy;
        logic [CW-1:0] exp_cred;
        logic          exp_sv;
        logic [W-1:0]  exp_smsg;
        logic          exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the scoreboard against the send stream after an edge.
    task automatic score_send();
        logic [W-1:0] e;
        if (send_val === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("send_unexpected", 32'(send_msg), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("send_msg_sb", 32'(send_msg), 32'(e));
            end
        end
    endtask

    // Driver task: run one cycle of stimulus with its expected results.
    task automatic do_cycle(input vec_t v);
        @(negedge clk);
        enq_val    = v.ev;
        enq_msg    = v.msg;
        credit_ret = v.cr;
        #1;
        check("enq_rdy", 32'(enq_rdy), 32'(v.exp_rdy));
        if (v.ev && v.exp_rdy) exp_q.push_back(v.msg);
        @(posedge clk);
        #1;
        check("credits", 32'(credits), 32'(v.exp_cred));
        check("send_val", 32'(send_val), 32'(v.exp_sv));
        check("send_msg", 32'(send_msg), 32'(v.exp_smsg));
        check("credit_err", 32'(credit_err), 32'(v.exp_err));
        score_send();
    endtask

    initial begin
        vec_t          v;
        logic [CW-1:0] m_cred;
        logic          m_err;
        logic [W-1:0]  m_msg;
        logic          acc;

        reset      = 1'b0;
        enq_val    = 1'b0;
        enq_msg    = '0;
        credit_ret = 1'b0;

        //             ev    msg    cr    rdy   cred sv    smsg   err
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 2'd1, 1'b1, 8'hA1, 1'b0};
        vecs[4]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA2, 1'b0};
        vecs[5]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 2'd0, 1'b0, 8'hA2, 1'b0};
        vecs[6]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 2'd1, 1'b0, 8'hA2, 1'b0};
        vecs[7]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA3, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0, 8'hA3, 1'b0};
        vecs[9]  = '{1'b1, 8'hB0, 1'b1, 1'b1, 2'd1, 1'b1, 8'hB0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 8'hB0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 8'hB0, 1'b1};
        vecs[12] = '{1'b1, 8'hC1, 1'b0, 1'b1, 2'd1, 1'b1, 8'hC1, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd2, 1'b0, 8'hC1, 1'b1};

        // Check the outputs while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_credits", 32'(credits), 32'd2);
        check("rst_enq_rdy", 32'(enq_rdy), 32'd1);
        check("rst_send_val", 32'(send_val), 32'd0);
        check("rst_send_msg", 32'(send_msg), 32'd0);
        check("rst_credit_err", 32'(credit_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Apply the directed vector table.
        for (int i = 0; i < 14; i++) do_cycle(vecs[i]);
        check("sb_empty_table", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of traffic: credits=0, send_val=1, err=1.
        do_cycle('{1'b1, 8'hD1, 1'b0, 1'b1, 2'd1, 1'b1, 8'hD1, 1'b1});
        do_cycle('{1'b1, 8'hD2, 1'b0, 1'b1, 2'd0, 1'b1, 8'hD2, 1'b1});
        #2;
        reset = 1'b0;
        #1;
        check("arst_credits", 32'(credits), 32'd2);
        check("arst_send_val", 32'(send_val), 32'd0);
        check("arst_send_msg", 32'(send_msg), 32'd0);
        check("arst_credit_err", 32'(credit_err), 32'd0);
        check("arst_enq_rdy", 32'(enq_rdy), 32'd1);
        check("sb_empty_arst", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        enq_val    = 1'b0;
        credit_ret = 1'b0;
        reset      = 1'b1;

        // Random traffic checked against a small credit model.
        m_cred = CW'(NC);
        m_err  = 1'b0;
        m_msg  = '0;
        for (int n = 0; n < 300; n++) begin
            v.ev  = 1'($urandom_range(0, 1));
            v.msg = W'($urandom_range(0, 255));
            v.cr  = (m_cred < CW'(NC)) ? 1'($urandom_range(0, 1))
                                       : ($urandom_range(0, 15) == 0);
            v.exp_rdy = (m_cred != 0);
            acc = v.ev && v.exp_rdy;
            if (acc && !v.cr) m_cred = m_cred - 1'b1;
            else if (!acc && v.cr) begin
                if (m_cred == CW'(NC)) m_err = 1'b1;
                else m_cred = m_cred + 1'b1;
            end
            if (acc) m_msg = v.msg;
            v.exp_cred = m_cred;
            v.exp_sv   = acc;
            v.exp_smsg = m_msg;
            v.exp_err  = m_err;
            do_cycle(v);
        end
        check("sb_empty_final", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
